// File: rtl/c3lib_strap_ctrl.sv
// ---------------------------------------------------------------------------
// c3lib_strap_ctrl
//
// Qualifies the raw outputs of a metal-programmable tie-cell strap array and
// presents them as a locked configuration word. The straps must read the
// same value for STABLE_CYC consecutive edges before they are locked. If they
// keep changing, the lock is forced after MAX_RETRY mismatches and
// err_unstable is raised. A relock pulse restarts qualification.
//
// Optional feature (macro C3LIB_STRAP_OVRD_EN):
//   defined   - handshaked runtime override of the locked word
//               (ovrd_req / ovrd_data / ovrd_ack).
//   undefined - override inputs are ignored, ovrd_ack and cfg_src read 0.
//
// Parameters:
//   WIDTH        number of strap bits
//   STABLE_CYC   consecutive identical samples required to lock (>= 2)
//   MAX_RETRY    sample mismatches tolerated before a forced lock (>= 1)
//
// Ports:
//   clk           block clock
//   rst           synchronous active-high reset
//   strap_in      raw strap bits from the tie-cell array
//   relock        single-cycle re-qualification request
//   ovrd_req      override request (level)
//   ovrd_data     override value, stable while ovrd_req is high
//   ovrd_ack      one-cycle pulse when an override is applied
//   cfg_out       qualified configuration word
//   cfg_valid     cfg_out is locked and usable
//   cfg_src       source of cfg_out: 0 = straps, 1 = override
//   err_unstable  sticky: lock was forced after MAX_RETRY mismatches
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module c3lib_strap_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned MAX_RETRY  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             relock,
  input  logic             ovrd_req,
  input  logic [WIDTH-1:0] ovrd_data,
  output logic             ovrd_ack,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             cfg_src,
  output logic             err_unstable
);

  localparam int unsigned CW = $clog2(STABLE_CYC + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] CNT_LOCK  = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic {
    ST_SAMPLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] w_sample_nxt;
  logic [WIDTH-1:0] r_cfg;
  logic [WIDTH-1:0] w_cfg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [RW-1:0]    r_retry;
  logic [RW-1:0]    w_retry_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_src;
  logic             w_src_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic             w_match;
  logic [CW-1:0]    w_cnt_inc;
  logic [RW-1:0]    w_retry_inc;
  logic             w_ovrd_take;

  assign w_match     = (strap_in == r_sample);
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_retry_inc = r_retry + 1'b1;

  // -------------------------------------------------------------------------
  // Override handshake
  // -------------------------------------------------------------------------
`ifdef C3LIB_STRAP_OVRD_EN
  logic r_ack;
  logic r_req_seen;

  // relock has priority; a request arriving in SAMPLE stays pending because
  // req_seen only sets on an actual accept.
  assign w_ovrd_take = (r_state == ST_LOCKED) && !relock && ovrd_req && !r_req_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_req_seen <= 1'b0;
    end else begin
      r_ack      <= w_ovrd_take;
      r_req_seen <= ovrd_req ? (r_req_seen | w_ovrd_take) : 1'b0;
    end
  end

  assign ovrd_ack = r_ack;
`else
  logic w_unused_ovrd;

  assign w_unused_ovrd = ovrd_req ^ (^ovrd_data);
  assign w_ovrd_take   = 1'b0;
  assign ovrd_ack      = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Qualification FSM: next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_sample_nxt = r_sample;
    w_cfg_nxt    = r_cfg;
    w_cnt_nxt    = r_cnt;
    w_retry_nxt  = r_retry;
    w_valid_nxt  = r_valid;
    w_src_nxt    = r_src;
    w_err_nxt    = r_err;

    case (r_state)
      ST_SAMPLE: begin
        if (relock) begin
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end else if (r_cnt == '0) begin
          w_sample_nxt = strap_in;
          w_cnt_nxt    = CNT_ONE;
        end else if (w_match) begin
          if (w_cnt_inc == CNT_LOCK) begin
            w_cfg_nxt   = r_sample;
            w_valid_nxt = 1'b1;
            w_src_nxt   = 1'b0;
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_sample_nxt = strap_in;
          w_cnt_nxt    = CNT_ONE;
          if (w_retry_inc == RETRY_LIM) begin
            // Forced lock takes the newest value. Counters are cleared so a
            // later relock gets a full retry budget again.
            w_cfg_nxt   = strap_in;
            w_valid_nxt = 1'b1;
            w_src_nxt   = 1'b0;
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end else begin
            w_retry_nxt = w_retry_inc;
          end
        end
      end

      ST_LOCKED: begin
        if (relock) begin
          // cfg_out keeps its old value until the next lock.
          w_valid_nxt = 1'b0;
          w_src_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SAMPLE;
        end else if (w_ovrd_take) begin
          w_cfg_nxt = ovrd_data;
          w_src_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_SAMPLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_SAMPLE;
      r_sample <= '0;
      r_cfg    <= '0;
      r_cnt    <= '0;
      r_retry  <= '0;
      r_valid  <= 1'b0;
      r_src    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sample <= w_sample_nxt;
      r_cfg    <= w_cfg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_retry  <= w_retry_nxt;
      r_valid  <= w_valid_nxt;
      r_src    <= w_src_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign cfg_out      = r_cfg;
  assign cfg_valid    = r_valid;
  assign cfg_src      = r_src;
  assign err_unstable = r_err;

endmodule

// File: tb/tb_c3lib_strap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_c3lib_strap_ctrl
//
// Self-checking bench for c3lib_strap_ctrl. A behavioural reference model
// keeps the history of strap samples taken since qualification began and
// derives lock / forced-lock from that history (trailing run length and
// number of value changes). Every output is compared after every edge, and
// directed checks cover the named scenarios. Honors C3LIB_STRAP_OVRD_EN.
// ---------------------------------------------------------------------------
module tb_c3lib_strap_ctrl;

  localparam int unsigned W      = 8;
  localparam int unsigned STABLE = 4;
  localparam int unsigned RETRY  = 15;
`ifdef C3LIB_STRAP_OVRD_EN
  localparam bit OVRD = 1'b1;
`else
  localparam bit OVRD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] strap_in;
  logic         relock;
  logic         ovrd_req;
  logic [W-1:0] ovrd_data;
  logic         ovrd_ack;
  logic [W-1:0] cfg_out;
  logic         cfg_valid;
  logic         cfg_src;
  logic         err_unstable;

  c3lib_strap_ctrl #(
    .WIDTH      (W),
    .STABLE_CYC (STABLE),
    .MAX_RETRY  (RETRY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .strap_in     (strap_in),
    .relock       (relock),
    .ovrd_req     (ovrd_req),
    .ovrd_data    (ovrd_data),
    .ovrd_ack     (ovrd_ack),
    .cfg_out      (cfg_out),
    .cfg_valid    (cfg_valid),
    .cfg_src      (cfg_src),
    .err_unstable (err_unstable)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] hist[$];
  logic [W-1:0] m_cfg;
  logic         m_valid, m_src, m_ack, m_err, m_locked, m_seen;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int run;
    int changes;
    int n;
    m_ack = 1'b0;
    if (rst) begin
      hist.delete();
      m_cfg = '0; m_valid = 1'b0; m_src = 1'b0; m_err = 1'b0;
      m_locked = 1'b0; m_seen = 1'b0;
      return;
    end
    if (!m_locked) begin
      if (relock) begin
        hist.delete();
      end else begin
        hist.push_back(strap_in);
        n = hist.size();
        run = 1;
        for (int i = n - 1; i > 0; i--) begin
          if (hist[i] == hist[i-1]) run++;
          else break;
        end
        changes = 0;
        for (int i = 1; i < n; i++)
          if (hist[i] != hist[i-1]) changes++;
        if (n > 1 && hist[n-1] != hist[n-2] && changes == int'(RETRY)) begin
          m_cfg = strap_in; m_valid = 1'b1; m_src = 1'b0; m_err = 1'b1;
          m_locked = 1'b1;
          hist.delete();
        end else if (run == int'(STABLE)) begin
          m_cfg = hist[n-1]; m_valid = 1'b1; m_src = 1'b0;
          m_locked = 1'b1;
          hist.delete();
        end
      end
    end else begin
      if (relock) begin
        m_valid = 1'b0; m_src = 1'b0; m_locked = 1'b0;
      end else if (OVRD && ovrd_req && !m_seen) begin
        m_cfg = ovrd_data; m_src = 1'b1; m_ack = 1'b1; m_seen = 1'b1;
      end
    end
    if (!ovrd_req) m_seen = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cfg_out", cfg_out, m_cfg);
    chk("cfg_valid", W'(cfg_valid), W'(m_valid));
    chk("cfg_src", W'(cfg_src), W'(m_src));
    chk("ovrd_ack", W'(ovrd_ack), W'(m_ack));
    chk("err_unstable", W'(err_unstable), W'(m_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int acks;

  initial begin
    rst = 1'b1; relock = 1'b0; ovrd_req = 1'b0; ovrd_data = '0; strap_in = 8'hA5;
    m_cfg = '0; m_valid = 1'b0; m_src = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    m_locked = 1'b0; m_seen = 1'b0;

    // Reset state and clean lock
    ticks(2);
    chk("rst_valid", W'(cfg_valid), 8'h00);
    chk("rst_cfg", cfg_out, 8'h00);
    rst = 1'b0;
    ticks(3);
    chk("clean_pre_lock", W'(cfg_valid), 8'h00);
    tick();
    chk("clean_valid", W'(cfg_valid), 8'h01);
    chk("clean_cfg", cfg_out, 8'hA5);
    chk("clean_err", W'(err_unstable), 8'h00);

    // Glitch restart: lock at edge 1 + STABLE
    relock = 1'b1; tick(); relock = 1'b0;
    chk("relock_valid", W'(cfg_valid), 8'h00);
    chk("relock_cfg_hold", cfg_out, 8'hA5);
    strap_in = 8'hA5; tick();
    strap_in = 8'h5A; ticks(3);
    chk("glitch_pre_lock", W'(cfg_valid), 8'h00);
    tick();
    chk("glitch_valid", W'(cfg_valid), 8'h01);
    chk("glitch_cfg", cfg_out, 8'h5A);

    // Forced lock: strap changes every edge
    relock = 1'b1; tick(); relock = 1'b0;
    for (int i = 0; i < 16; i++) begin
      strap_in = 8'(i * 29 + 3);
      tick();
      if (i == 14) chk("forced_pre_lock", W'(cfg_valid), 8'h00);
    end
    chk("forced_valid", W'(cfg_valid), 8'h01);
    chk("forced_err", W'(err_unstable), 8'h01);
    chk("forced_cfg", cfg_out, 8'(15 * 29 + 3));
    relock = 1'b1; tick(); relock = 1'b0;
    strap_in = 8'hC0; ticks(4);
    chk("err_sticky_valid", W'(cfg_valid), 8'h01);
    chk("err_sticky", W'(err_unstable), 8'h01);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("err_cleared", W'(err_unstable), 8'h00);

    // Override: held request acknowledged once, re-armed by a low cycle
    strap_in = 8'hA5; ticks(4);
    ovrd_req = 1'b1; ovrd_data = 8'h3C; acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acks += int'(ovrd_ack);
    end
    chk("ovrd_ack_once", 8'(acks), 8'(OVRD));
    chk("ovrd_cfg", cfg_out, OVRD ? 8'h3C : 8'hA5);
    ovrd_req = 1'b0; tick();
    ovrd_req = 1'b1; tick();
    chk("ovrd_rearm_ack", W'(ovrd_ack), W'(OVRD));
    tick();

    // Simultaneous relock and fresh request: relock wins, ack after re-lock
    ovrd_req = 1'b0; tick();
    relock = 1'b1; ovrd_req = 1'b1; ovrd_data = 8'hC3; tick(); relock = 1'b0;
    chk("sim_valid", W'(cfg_valid), 8'h00);
    chk("sim_no_ack", W'(ovrd_ack), 8'h00);
    ticks(4);
    chk("sim_lock_valid", W'(cfg_valid), 8'h01);
    chk("sim_lock_no_ack", W'(ovrd_ack), 8'h00);
    tick();
    chk("sim_late_ack", W'(ovrd_ack), W'(OVRD));
    chk("sim_cfg", cfg_out, OVRD ? 8'hC3 : 8'hA5);

    // Reset in SAMPLE with cnt = 2
    ovrd_req = 1'b0;
    relock = 1'b1; tick(); relock = 1'b0;
    ticks(2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_sample_cfg", cfg_out, 8'h00);
    chk("rst_sample_valid", W'(cfg_valid), 8'h00);

    // Reset during an ack cycle
    ticks(4);
    ovrd_req = 1'b1; ovrd_data = 8'h99; tick();
    rst = 1'b1; tick(); rst = 1'b0; ovrd_req = 1'b0;
    chk("rst_ack_ack", W'(ovrd_ack), 8'h00);
    chk("rst_ack_src", W'(cfg_src), 8'h00);
    chk("rst_ack_cfg", cfg_out, 8'h00);

    // Randomized traffic, alternating quiet and noisy strap phases
    for (int k = 0; k < 800; k++) begin
      rst    = ($urandom_range(149) == 0);
      relock = ($urandom_range(24) == 0);
      if (((k / 100) % 2) == 1) begin
        strap_in = 8'($urandom);
      end else if ($urandom_range(5) == 0) begin
        case ($urandom_range(3))
          0: strap_in = 8'hA5;
          1: strap_in = 8'h5A;
          2: strap_in = 8'h3C;
          default: strap_in = 8'hFF;
        endcase
      end
      if ($urandom_range(5) == 0) ovrd_req = ~ovrd_req;
      if (!ovrd_req) ovrd_data = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
